// File: rtl/div_repsub.sv
// Unsigned repeated-subtraction divider.
// Dividend and divisor are loaded on consecutive cycles over a shared bus
// after a start request. The divisor is then subtracted from the running
// remainder once per cycle, and the quotient counts the subtractions.
// Results are held with done=1 until the next accepted start or reset.
module div_repsub #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             done,
   output logic             busy,
   output logic             dbz
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LD_DVD = 3'd1,
      S_LD_DVS = 3'd2,
      S_CHECK  = 3'd3,
      S_SUB    = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t           state_reg;
   logic [WIDTH-1:0] quotient_reg;
   logic [WIDTH-1:0] remainder_reg;
   logic [WIDTH-1:0] dvs_reg;
   logic             done_reg;
   logic             busy_reg;
   logic             dbz_reg;

   // Datapath: the next partial remainder. SUB is only ever entered with
   // remainder >= divisor, so this difference never underflows there.
   logic [WIDTH-1:0] diff;
   logic             diff_lt_dvs;
   logic             rem_lt_dvs;
   logic             dvs_zero;

   // Datapath comparisons feeding the controller.
   always_comb begin
      diff        = remainder_reg - dvs_reg;
      diff_lt_dvs = (diff < dvs_reg);
      rem_lt_dvs  = (remainder_reg < dvs_reg);
      dvs_zero    = (dvs_reg == '0);
   end

   // Controller and result registers: one Moore FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= S_IDLE;
         quotient_reg  <= '0;
         remainder_reg <= '0;
         dvs_reg       <= '0;
         done_reg      <= 1'b0;
         busy_reg      <= 1'b0;
         dbz_reg       <= 1'b0;
      end else begin
         case (state_reg)
            // Idle and done both accept a new request; the clearing of the
            // previous result flags is identical in both.
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_reg    <= S_LD_DVD;
                  quotient_reg <= '0;
                  done_reg     <= 1'b0;
                  dbz_reg      <= 1'b0;
                  busy_reg     <= 1'b1;
               end
            end

            // First operand on the shared bus is the dividend; it seeds the
            // running remainder directly.
            S_LD_DVD: begin
               remainder_reg <= data_in;
               state_reg     <= S_LD_DVS;
            end

            // Second operand is the divisor.
            S_LD_DVS: begin
               dvs_reg   <= data_in;
               state_reg <= S_CHECK;
            end

            // Resolve the trivial cases without entering the subtract loop.
            S_CHECK: begin
               if (dvs_zero) begin
                  // Divide by zero: saturate the quotient and keep the
                  // dividend visible in the remainder.
                  quotient_reg <= '1;
                  dbz_reg      <= 1'b1;
                  done_reg     <= 1'b1;
                  busy_reg     <= 1'b0;
                  state_reg    <= S_DONE;
               end else if (rem_lt_dvs) begin
                  done_reg  <= 1'b1;
                  busy_reg  <= 1'b0;
                  state_reg <= S_DONE;
               end else begin
                  state_reg <= S_SUB;
               end
            end

            // One subtraction per cycle; finish on the same edge that leaves
            // a remainder smaller than the divisor. The quotient cannot wrap
            // because at most 2^WIDTH-1 subtractions fit (divisor of one).
            S_SUB: begin
               remainder_reg <= diff;
               quotient_reg  <= quotient_reg + WIDTH'(1);
               if (diff_lt_dvs) begin
                  done_reg  <= 1'b1;
                  busy_reg  <= 1'b0;
                  state_reg <= S_DONE;
               end
            end

            // Unreachable encodings recover to idle with the flags cleared.
            default: begin
               state_reg <= S_IDLE;
               done_reg  <= 1'b0;
               busy_reg  <= 1'b0;
               dbz_reg   <= 1'b0;
            end
         endcase
      end
   end

   assign quotient  = quotient_reg;
   assign remainder = remainder_reg;
   assign done      = done_reg;
   assign busy      = busy_reg;
   assign dbz       = dbz_reg;

endmodule

// File: tb/tb_div_repsub.sv
// Self-checking bench for div_repsub: a cycle-level reference model built
// from plain division arithmetic, a per-cycle compare process, and directed
// vectors with hand-computed results.
module tb_div_repsub;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] data_in = '0;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         done;
   logic         busy;
   logic         dbz;

   int checks = 0;
   int failures = 0;

   div_repsub #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .data_in  (data_in),
      .quotient (quotient),
      .remainder(remainder),
      .done     (done),
      .busy     (busy),
      .dbz      (dbz)
   );

   always #5 clk = ~clk;

   // Reference model state, advanced on each rising edge.
   bit m_valid = 1'b0;   // a reset has been seen, outputs are defined
   bit m_zero  = 1'b0;   // all outputs zero since reset, no request yet
   bit m_busy  = 1'b0;
   bit m_done  = 1'b0;
   int m_cnt   = 0;      // edges elapsed since the accepting edge
   int m_dvd   = 0;
   int m_dvs   = 0;
   int m_k     = 0;      // index of the accepting edge
   int edge_no = 0;      // index of the most recent rising edge

   // Total edges from acceptance to done: three for loading and checking,
   // plus one per unit of quotient when the subtract loop runs.
   function automatic int model_lat(input int dvd, input int dvs);
      if (dvs == 0 || dvd < dvs) return 3;
      return 3 + dvd / dvs;
   endfunction

   always @(posedge clk) begin
      edge_no <= edge_no + 1;
      if (rst) begin
         m_valid <= 1'b1;
         m_zero  <= 1'b1;
         m_busy  <= 1'b0;
         m_done  <= 1'b0;
         m_cnt   <= 0;
      end else if (!m_busy && start) begin
         m_zero <= 1'b0;
         m_busy <= 1'b1;
         m_done <= 1'b0;
         m_cnt  <= 0;
         m_k    <= edge_no + 1;
      end else if (m_busy) begin
         m_cnt <= m_cnt + 1;
         if (m_cnt == 0) m_dvd <= int'(data_in);
         if (m_cnt == 1) m_dvs <= int'(data_in);
         if (m_cnt >= 2 && m_cnt + 1 == model_lat(m_dvd, m_dvs)) begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   logic [W-1:0] e_q, e_r;
   logic         e_dbz;
   bit           chk_r;
   int           j;
   always @(negedge clk) begin
      if (m_valid) begin
         chk_r = 1'b1;
         e_dbz = 1'b0;
         e_q   = '0;
         e_r   = '0;
         if (m_zero) begin
            e_q = '0;
            e_r = '0;
         end else if (m_done) begin
            if (m_dvs == 0) begin
               e_dbz = 1'b1;
               e_q   = '1;
               e_r   = W'(m_dvd);
            end else begin
               e_q = W'(m_dvd / m_dvs);
               e_r = W'(m_dvd % m_dvs);
            end
         end else if (m_busy) begin
            if (m_cnt == 0) begin
               chk_r = 1'b0;    // previous remainder still held, not yet loaded
            end else if (m_cnt < 3) begin
               e_r = W'(m_dvd);
            end else begin
               j   = m_cnt - 3;
               e_q = W'(j);
               e_r = W'(m_dvd - j * m_dvs);
            end
         end
         checks++;
         if (done !== m_done || busy !== m_busy || dbz !== e_dbz ||
             quotient !== e_q || (chk_r && remainder !== e_r)) begin
            failures++;
            $display("FAIL model_cycle edge=%0d got done=%b busy=%b dbz=%b q=%0d r=%0d want done=%b busy=%b dbz=%b q=%0d r=%0d",
                     edge_no, done, busy, dbz, quotient, remainder,
                     m_done, m_busy, e_dbz, e_q, e_r);
         end
      end
   end

   task automatic check_val(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   // Pulse start, then present dividend and divisor on the following cycles.
   // Returns at the falling edge after the divisor has been captured.
   task automatic load(input int dvd, input int dvs);
      @(negedge clk);
      start = 1'b1;
      data_in = '0;
      @(negedge clk);
      start = 1'b0;
      data_in = W'(dvd);
      check_val("accept_clears_done", int'(done), 0);
      check_val("accept_sets_busy", int'(busy), 1);
      @(negedge clk);
      data_in = W'(dvs);
      @(negedge clk);
      data_in = '0;
   endtask

   task automatic wait_done(input string name, input int eq, input int er,
                            input int edbz, input int elat);
      int n = 0;
      while (done !== 1'b1 && n < 70000) begin
         @(negedge clk);
         n++;
      end
      if (done !== 1'b1) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout got done=%b want done=1", name, done);
      end else begin
         check_val({name, "_q"}, int'(quotient), eq);
         check_val({name, "_r"}, int'(remainder), er);
         check_val({name, "_dbz"}, int'(dbz), edbz);
         check_val({name, "_lat"}, edge_no - m_k, elat);
         $display("%s: q=%0d r=%0d dbz=%b latency=%0d", name, quotient,
                  remainder, dbz, edge_no - m_k);
      end
   endtask

   initial begin
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check_val("reset_q", int'(quotient), 0);
      check_val("reset_r", int'(remainder), 0);
      check_val("reset_done", int'(done), 0);
      check_val("reset_busy", int'(busy), 0);
      check_val("reset_dbz", int'(dbz), 0);

      load(100, 7);
      wait_done("div_100_7", 14, 2, 0, 17);

      load(5, 9);
      wait_done("div_5_9", 0, 5, 0, 3);

      load(42, 0);
      wait_done("div_42_0", 65535, 42, 1, 3);

      load(65535, 1);
      wait_done("div_65535_1", 65535, 0, 0, 65538);

      // Reset in the middle of the subtract loop.
      load(1000, 3);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_val("midrst_q", int'(quotient), 0);
      check_val("midrst_r", int'(remainder), 0);
      check_val("midrst_done", int'(done), 0);
      check_val("midrst_busy", int'(busy), 0);
      $display("mid_sub_reset: q=%0d r=%0d done=%b busy=%b", quotient,
               remainder, done, busy);

      load(12, 4);
      wait_done("div_12_4", 3, 0, 0, 6);

      // Start pulsed while the subtract loop runs must be ignored.
      load(21, 21);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("div_21_21", 1, 0, 0, 4);

      // Restart directly from the done state.
      load(9, 2);
      wait_done("div_9_2", 4, 1, 0, 7);

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/div_repsub.md
Name: div_repsub

Overview:
- Unsigned integer divider using repeated subtraction; the inverse of the repeated-addition multiplier.
- Uses the same shared-bus operand loading (data_in), start/done handshake, and datapath-plus-controller structure as the multiplier.
- Sits beside the multiplier in the arithmetic block set.
- Dividend and divisor arrive on consecutive cycles after start. Quotient and remainder are held until the next start.

Parameters:
- WIDTH, 16, operand, quotient and remainder width in bits.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a division; sampled only in IDLE and DONE.
- data_in  input  WIDTH  shared operand bus: dividend, then divisor.
- quotient  output  WIDTH  quotient register; valid only while done=1.
- remainder  output  WIDTH  remainder register; valid only while done=1.
- done  output  1  result valid; held high until the next accepted start or rst.
- busy  output  1  high from LD_DVD through SUB.
- dbz  output  1  divide-by-zero flag; valid with done.

Behaviour:
- Reset (rst=1 at an edge, overrides all other activity, including mid-operation): state=IDLE; quotient, remainder and internal divisor register D = 0; done, busy, dbz = 0.
- States: IDLE, LD_DVD, LD_DVS, CHECK, SUB, DONE. Registered Moore outputs; no # delays in RTL.
- Let k = the edge at which start is accepted.
- IDLE: start=1 -> LD_DVD. At edge k: done, dbz and quotient cleared, busy set.
- LD_DVD: at edge k+1, remainder <= data_in (dividend) -> LD_DVS.
- LD_DVS: at edge k+2, D <= data_in (divisor) -> CHECK.
- CHECK, evaluated at edge k+3:
  - D==0 -> DONE, dbz<=1, quotient<=all ones, remainder keeps dividend.
  - remainder<D -> DONE, quotient=0.
  - Otherwise -> SUB.
- SUB, each edge:
  - remainder <= remainder-D and quotient <= quotient+1.
  - If (remainder-D)<D, go to DONE on the same edge; else stay in SUB.
- DONE: done=1, busy=0, outputs frozen.
  - start=1 -> LD_DVD with the same clearing as from IDLE.
  - start=0 -> stay in DONE.
- Latency: done is first high after edge k+3+Q, where Q is the final quotient (Q=0 and dbz cases: k+3). Worst case is 2^WIDTH+2 cycles.
- Width rules:
  - All arithmetic is unsigned WIDTH-bit.
  - Subtraction never underflows, because it is entered only when remainder>=D.
  - The quotient cannot wrap: max Q = 2^WIDTH-1, which occurs when D=1.
- start is ignored while busy=1. start held high in DONE restarts on every acceptance; the bench pulses start for one cycle.
- Unknown or illegal state encodings go to IDLE on the next edge.
- quotient and remainder change visibly during SUB; consumers must qualify them with done.

Test Plan:
- 100/7: start pulse, data_in=100 then 7 -> quotient=14, remainder=2, dbz=0, done first high after edge k+17.
- 5/9 -> quotient=0, remainder=5, done after edge k+3, no SUB cycles.
- 42/0 -> dbz=1, quotient=16'hFFFF, remainder=16'h002A, done after edge k+3.
- 65535/1 -> quotient=65535, remainder=0, done after edge k+65538, no wrap.
- 1000/3 with rst asserted for one cycle mid-SUB -> next cycle all outputs 0, state IDLE. Then 12/4 -> quotient=3, remainder=0.
- 21/21 with start re-pulsed during SUB (ignored) -> quotient=1, remainder=0, done after edge k+4. Then start in DONE with 9/2 -> done drops at accept, then quotient=4, remainder=1.
